// File: rtl/fp16_unit_arbiter.sv
// Purpose : round-robin share of one fp16 unit (start/clear/valid) among NUM_REQ requesters.
// Latency : gnt at T, unit_start at T+1, rsp_valid at T+3 minimum; grants at least 4 cycles apart.
// Backpr. : one op in flight; new requests wait until IDLE; WAIT holds until unit_valid (or timeout).
//
// Ports: clk/reset_b (async active-low); req/req_a/req_b per-requester level request + operands
// (requester i at [16*i+15:16*i]); gnt one-hot accept pulse; rsp_valid/rsp_result/rsp_err
// one-hot response pulse; busy; unit_start/unit_clear/unit_a/unit_b/unit_valid/unit_result
// to the shared unit. Optional macro FP16_ARB_TIMEOUT_EN adds a WAIT timeout that aborts
// with qNaN (16'h7E00) and rsp_err=1 after TIMEOUT_CYCLES cycles.
module fp16_unit_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   reset_b,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [16*NUM_REQ-1:0]  req_a,
    input  logic [16*NUM_REQ-1:0]  req_b,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [15:0]            rsp_result,
    output logic                   rsp_err,
    output logic                   busy,
    output logic                   unit_start,
    output logic                   unit_clear,
    output logic [15:0]            unit_a,
    output logic [15:0]            unit_b,
    input  logic                   unit_valid,
    input  logic [15:0]            unit_result
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("fp16_unit_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   owner;
    logic [15:0]        res;
    logic               to_hit;

    // Rotate requests so bit 0 is the requester at the pointer; the lowest
    // set bit of the rotated vector is then the round-robin winner.
    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [IDX_W-1:0]     win_off;
    logic [IDX_W:0]       win_sum;
    logic [IDX_W-1:0]     win_idx;
    logic                 win_vld;
    logic [15:0]          win_a;
    logic [15:0]          win_b;

    assign req_dbl = {req, req} >> ptr;
    assign req_rot = req_dbl[NUM_REQ-1:0];
    assign win_vld = |req_rot;
    assign win_sum = {1'b0, ptr} + {1'b0, win_off};
    assign win_idx = IDX_W'((win_sum >= (IDX_W+1)'(NUM_REQ)) ? win_sum - (IDX_W+1)'(NUM_REQ) : win_sum);

    always_comb begin
        win_off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) win_off = IDX_W'(i);
        end
    end

    always_comb begin
        win_a = '0;
        win_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IDX_W'(i)) begin
                win_a = req_a[16*i +: 16];
                win_b = req_b[16*i +: 16];
            end
        end
    end

`ifdef FP16_ARB_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic             err;

    // A valid arriving in the last WAIT cycle wins over the abort.
    assign to_hit  = (state == S_WAIT) && !unit_valid && (cnt == CNT_LAST);
    assign rsp_err = (state == S_DONE) && err;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            if (state == S_ISSUE) begin
                cnt <= '0;
            end else if (state == S_WAIT && !unit_valid) begin
                cnt <= cnt + 1'b1;
            end
            if (state == S_WAIT && unit_valid) begin
                err <= 1'b0;
            end else if (to_hit) begin
                err <= 1'b1;
            end
        end
    end
`else
    assign to_hit  = 1'b0;
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        gnt        = '0;
        rsp_valid  = '0;
        rsp_result = '0;
        busy       = 1'b1;
        unit_start = 1'b0;
        unit_clear = 1'b0;
        unique case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (win_vld) begin
                    gnt       = ONE_HOT0 << win_idx;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                unit_start = 1'b1;
                state_nxt  = S_WAIT;
            end
            S_WAIT: begin
                if (unit_valid || to_hit) state_nxt = S_DONE;
            end
            S_DONE: begin
                rsp_valid  = ONE_HOT0 << owner;
                rsp_result = res;
                unit_clear = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            ptr    <= '0;
            owner  <= '0;
            unit_a <= '0;
            unit_b <= '0;
            res    <= '0;
        end else begin
            if (state == S_IDLE && win_vld) begin
                unit_a <= win_a;
                unit_b <= win_b;
                owner  <= win_idx;
            end
            if (state == S_WAIT) begin
                if (unit_valid) begin
                    res <= unit_result;
                end else if (to_hit) begin
                    res <= 16'h7E00;
                end
            end
            // Owner drops to lowest priority for the next arbitration.
            if (state == S_DONE) begin
                ptr <= (owner == LAST_IDX) ? '0 : owner + 1'b1;
            end
        end
    end

endmodule
